// File: rtl/mem_req_seq.sv
// ---------------------------------------------------------------------------
// mem_req_seq
//
// Request sequencer sitting between the CPU bus and the SRAM memory
// controller. Single-beat CPU requests arrive over a stb/ack handshake and
// are turned into controller accesses whose address, data, width and write
// enable are held stable for HOLD_CYC clocks. Writes are posted: the CPU is
// acked on the cycle after the write is accepted while the controller window
// still runs. Reads ack once the window ends, returning the controller data
// registered on that edge. After reset, the controller's active-low boot
// release is held low for BOOT_CYC clocks and CPU requests stall until then.
//
// Parameters
//   HOLD_CYC  clocks each controller access is held stable (2..15)
//   BOOT_CYC  clocks after reset with boot low and requests stalled (1..255)
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   cpu_adr    CPU byte address (passed through unmodified)
//   cpu_dat_i  CPU write data
//   cpu_we     1 = write, 0 = read
//   cpu_byte   1 = byte operation, 0 = word operation
//   cpu_stb    request valid, held by the CPU until cpu_ack
//   cpu_ack    one-cycle acknowledge
//   cpu_dat_o  read data, valid while cpu_ack is high on a read
//   addr_data  address to the memory controller
//   wr_data    write data to the memory controller
//   we         controller write enable, active low
//   w_b        controller width select, 1 = byte, 0 = word
//   rd_data    read data from the memory controller
//   boot       controller boot release, active low during the boot hold
//   busy       high while an access is in flight or the write buffer is full
// ---------------------------------------------------------------------------
module mem_req_seq #(
    parameter int HOLD_CYC = 5,
    parameter int BOOT_CYC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] cpu_adr,
    input  logic [15:0] cpu_dat_i,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic        cpu_stb,
    output logic        cpu_ack,
    output logic [15:0] cpu_dat_o,
    output logic [19:0] addr_data,
    output logic [15:0] wr_data,
    output logic        we,
    output logic        w_b,
    input  logic [15:0] rd_data,
    output logic        boot,
    output logic        busy
);

    localparam logic [7:0] BOOT_LOAD = 8'(BOOT_CYC - 1);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  boot_cnt;
    logic [3:0]  hold_cnt;

    // The controller-facing address/data/width registers already stay frozen
    // for the whole write window, so they double as the storage of the
    // one-entry posted-write buffer; only its occupancy flag is kept apart.
    logic        buf_valid;

    logic        accept;
    logic        accept_wr;
    logic        accept_rd;
    logic        boot_done;
    logic        hold_done;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. An access that is underway always runs its full
    // window, even if the CPU withdraws cpu_stb part way through.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_BOOT: begin
                if (boot_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept_wr) begin
                    state_next = ST_WRITE;
                end else if (accept_rd) begin
                    state_next = ST_READ;
                end
            end
            ST_WRITE: begin
                if (hold_done) begin
                    state_next = ST_IDLE;
                end
            end
            ST_READ: begin
                if (hold_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_BOOT;
        endcase
    end

    // Output / decode logic. A request is only taken from IDLE while cpu_ack
    // is low: the ack cycle belongs to the previous request, whose cpu_stb is
    // still visible, so accepting there would double-issue it and could also
    // produce two adjacent acks.
    always_comb begin
        accept    = (state == ST_IDLE) && cpu_stb && !cpu_ack;
        accept_wr = accept && cpu_we;
        accept_rd = accept && !cpu_we;
        boot_done = (boot_cnt == 8'd0);
        hold_done = (hold_cnt == 4'd0);
        busy      = (state != ST_IDLE) || buf_valid;
    end

    // Registered datapath: boot and hold counters, controller outputs, CPU
    // acknowledge and read-data capture. The controller outputs are only
    // loaded on the edge leaving IDLE and only restored (we) on the edge
    // returning to IDLE, so they never move inside an access window.
    always_ff @(posedge clk) begin
        if (reset) begin
            boot_cnt  <= BOOT_LOAD;
            hold_cnt  <= 4'd0;
            buf_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_dat_o <= 16'd0;
            addr_data <= 20'd0;
            wr_data   <= 16'd0;
            we        <= 1'b1;
            w_b       <= 1'b0;
            boot      <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            unique case (state)
                ST_BOOT: begin
                    if (boot_done) begin
                        boot <= 1'b1;
                    end else begin
                        boot_cnt <= boot_cnt - 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (accept_wr) begin
                        addr_data <= cpu_adr;
                        wr_data   <= cpu_dat_i;
                        w_b       <= cpu_byte;
                        we        <= 1'b0;
                        buf_valid <= 1'b1;
                        cpu_ack   <= 1'b1;
                        hold_cnt  <= HOLD_LOAD;
                    end else if (accept_rd) begin
                        addr_data <= cpu_adr;
                        w_b       <= cpu_byte;
                        we        <= 1'b1;
                        hold_cnt  <= HOLD_LOAD;
                    end
                end
                ST_WRITE: begin
                    if (hold_done) begin
                        we        <= 1'b1;
                        buf_valid <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                ST_READ: begin
                    // A read whose requester has gone away still finishes
                    // its window but returns nothing and leaves cpu_dat_o
                    // untouched.
                    if (hold_done) begin
                        if (cpu_stb) begin
                            cpu_dat_o <= rd_data;
                            cpu_ack   <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    we <= 1'b1;
                end
            endcase
        end
    end

endmodule
